// File: rtl/latch_chk_pkg.sv
// Shared types and constants for the latch response checker.
package latch_chk_pkg;

   localparam int DEFAULT_MAX_DELAY = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_TRACK = 2'b01,
      ST_HOLD  = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'b00,
      ERR_FOLLOW = 2'b01,
      ERR_HOLD   = 2'b10,
      ERR_COMP   = 2'b11
   } err_code_e;

   typedef struct packed {
      logic d;
      logic g;
      logic q;
      logic qb;
   } lat_sample_t;

   // Hold outranks follow, which outranks complement.
   function automatic err_code_e err_priority(input logic hold_v,
                                              input logic follow_v,
                                              input logic comp_v);
      err_code_e code;
      code = ERR_NONE;
      if (hold_v)        code = ERR_HOLD;
      else if (follow_v) code = ERR_FOLLOW;
      else if (comp_v)   code = ERR_COMP;
      return code;
   endfunction

endpackage

// File: rtl/settle_timer.sv
// Saturating up-counter: restarts at 0, reports settled once it reaches MAX_DELAY.
module settle_timer
   import latch_chk_pkg::*;
#(
   parameter int MAX_DELAY = DEFAULT_MAX_DELAY
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic settled
);

   localparam int            TW      = (MAX_DELAY < 1) ? 1 : $clog2(MAX_DELAY + 1);
   localparam logic [TW-1:0] CNT_MAX = TW'(MAX_DELAY);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (restart)
         cnt_d = '0;
      else if (cnt_q != CNT_MAX)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign settled = (cnt_q == CNT_MAX);

endmodule

// File: rtl/latch_response_checker.sv
// Monitors a latch under test for follow, hold and complement violations.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | monitor disabled, no checks, settle timer held at 0
//   TRACK | gate high: q must follow d once settled
//   HOLD  | gate low: q must keep the d captured at the falling gate
module latch_response_checker
   import latch_chk_pkg::*;
#(
   parameter int MAX_DELAY = DEFAULT_MAX_DELAY,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             lat_d,
   input  logic             lat_g,
   input  logic             lat_q,
   input  logic             lat_qb,
   output logic [CNT_W-1:0] err_count,
   output logic             err_flag,
   output logic [1:0]       last_err,
   output logic [1:0]       state
);

   state_e           state_q, state_d;
   lat_sample_t      smp_q, smp_d;
   logic             d_prev_q, d_prev_d;
   logic             g_prev_q, g_prev_d;
   logic             expected_q, expected_d;
   logic             follow_done_q, follow_done_d;
   logic             hold_done_q, hold_done_d;
   logic             comp_done_q, comp_done_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic             err_flag_q, err_flag_d;
   err_code_e        last_err_q, last_err_d;

   logic in_track, in_hold, active;
   logic d_chg, g_edge, timer_restart, settled, chk_ok;
   logic follow_v, hold_v, comp_v, any_v;
   logic hold_entry;

   assign smp_d    = '{d: lat_d, g: lat_g, q: lat_q, qb: lat_qb};
   assign d_prev_d = smp_q.d;
   assign g_prev_d = smp_q.g;

   assign d_chg  = (smp_q.d != d_prev_q);
   assign g_edge = (smp_q.g != g_prev_q);

   // d is irrelevant while the latch is opaque, so it must not delay the hold check.
   assign timer_restart = (state_q == ST_IDLE) || g_edge || (d_chg && (state_q != ST_HOLD));

   settle_timer #(.MAX_DELAY(MAX_DELAY)) u_settle_timer (
      .clk     (clk),
      .rst     (rst),
      .restart (timer_restart),
      .settled (settled)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = smp_q.g ? ST_TRACK : ST_HOLD;
            ST_TRACK: if (!smp_q.g) state_d = ST_HOLD;
            ST_HOLD:  if (smp_q.g)  state_d = ST_TRACK;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      in_track = (state_q == ST_TRACK);
      in_hold  = (state_q == ST_HOLD);
      active   = (state_q != ST_IDLE);
      state    = state_q;
   end

   // An event seen this cycle has not yet reset the timer, so mask it here.
   assign chk_ok = en && settled && !timer_restart;

   assign follow_v = in_track && chk_ok && (smp_q.q != smp_q.d)     && !follow_done_q;
   assign hold_v   = in_hold  && chk_ok && (smp_q.q != expected_q)  && !hold_done_q;
   assign comp_v   = active   && chk_ok && (smp_q.qb == smp_q.q)    && !comp_done_q;
   assign any_v    = follow_v || hold_v || comp_v;

   assign hold_entry = (state_d == ST_HOLD) && (state_q != ST_HOLD);

   always_comb begin
      expected_d    = expected_q;
      follow_done_d = timer_restart ? 1'b0 : (follow_done_q | follow_v);
      hold_done_d   = hold_done_q | hold_v;
      comp_done_d   = (!active || (smp_q.qb != smp_q.q)) ? 1'b0 : (comp_done_q | comp_v);
      if (hold_entry) begin
         // Coming from IDLE there is no captured value; a d change at the
         // falling gate makes the capture ambiguous. Either way, skip this period.
         hold_done_d = (state_q == ST_IDLE) || d_chg;
         if (state_q == ST_TRACK)
            expected_d = smp_q.d;
      end
   end

   always_comb begin
      err_count_d = err_count_q;
      err_flag_d  = err_flag_q;
      last_err_d  = last_err_q;
      if (clr) begin
         err_count_d = '0;
         err_flag_d  = 1'b0;
         last_err_d  = ERR_NONE;
      end else if (any_v) begin
         if (!(&err_count_q))
            err_count_d = err_count_q + 1'b1;
         err_flag_d = 1'b1;
         last_err_d = err_priority(hold_v, follow_v, comp_v);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         smp_q         <= '0;
         d_prev_q      <= 1'b0;
         g_prev_q      <= 1'b0;
         expected_q    <= 1'b0;
         follow_done_q <= 1'b0;
         hold_done_q   <= 1'b0;
         comp_done_q   <= 1'b0;
         err_count_q   <= '0;
         err_flag_q    <= 1'b0;
         last_err_q    <= ERR_NONE;
      end else begin
         smp_q         <= smp_d;
         d_prev_q      <= d_prev_d;
         g_prev_q      <= g_prev_d;
         expected_q    <= expected_d;
         follow_done_q <= follow_done_d;
         hold_done_q   <= hold_done_d;
         comp_done_q   <= comp_done_d;
         err_count_q   <= err_count_d;
         err_flag_q    <= err_flag_d;
         last_err_q    <= last_err_d;
      end
   end

   assign err_count = err_count_q;
   assign err_flag  = err_flag_q;
   assign last_err  = last_err_q;

endmodule

// File: tb/tb_latch_response_checker.sv
// Directed bench for latch_response_checker with MAX_DELAY=4; a narrow-counter copy covers saturation.
module tb_latch_response_checker;

   logic        clk = 1'b0;
   logic        rst, en, clr;
   logic        lat_d, lat_g, lat_q, lat_qb;
   logic [15:0] err_count;
   logic        err_flag;
   logic [1:0]  last_err, state;
   logic [3:0]  err_count_s;
   logic        err_flag_s;
   logic [1:0]  last_err_s, state_s;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   latch_response_checker #(.MAX_DELAY(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .lat_d(lat_d), .lat_g(lat_g), .lat_q(lat_q), .lat_qb(lat_qb),
      .err_count(err_count), .err_flag(err_flag), .last_err(last_err), .state(state)
   );

   latch_response_checker #(.MAX_DELAY(4), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .lat_d(lat_d), .lat_g(lat_g), .lat_q(lat_q), .lat_qb(lat_qb),
      .err_count(err_count_s), .err_flag(err_flag_s), .last_err(last_err_s), .state(state_s)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_lat(input logic d, input logic g, input logic q, input logic qb);
      lat_d  = d;
      lat_g  = g;
      lat_q  = q;
      lat_qb = qb;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0;
      set_lat(0, 0, 0, 0);
      tick(3);
      check_eq("rst_state", state, 2'b00);
      check_eq("rst_count", err_count, 0);
      check_eq("rst_flag", err_flag, 0);
      check_eq("rst_last", last_err, 2'b00);
      rst = 1'b0;

      // TRACK, q follows d two cycles late
      set_lat(0, 1, 0, 1);
      tick(2);
      en = 1'b1;
      tick(10);
      check_eq("trk_state", state, 2'b01);
      check_eq("trk_count0", err_count, 0);
      lat_d = 1'b1;
      tick(2);
      lat_q = 1'b1; lat_qb = 1'b0;
      tick(10);
      check_eq("follow_ok_count", err_count, 0);
      check_eq("follow_ok_state", state, 2'b01);

      // q stuck low while d=1 -> exactly one follow-timeout
      set_lat(0, 1, 0, 1);
      tick(10);
      lat_d = 1'b1;
      tick(8);
      lat_q = 1'b1; lat_qb = 1'b0;
      tick(10);
      check_eq("follow_to_count", err_count, 1);
      check_eq("follow_to_last", last_err, 2'b01);
      check_eq("follow_to_flag", err_flag, 1);
      pulse_clr();
      check_eq("clr_count", err_count, 0);
      check_eq("clr_flag", err_flag, 0);
      check_eq("clr_last", last_err, 2'b00);

      // gate falls with d=1, d toggles in HOLD, q stays 1
      lat_g = 1'b0;
      tick(1);
      for (int i = 0; i < 7; i++) begin
         tick(3);
         lat_d = ~lat_d;
      end
      tick(2);
      check_eq("hold_dtog_count", err_count, 0);
      check_eq("hold_dtog_state", state, 2'b10);

      // q flips mid-HOLD -> one hold violation
      lat_q = 1'b0; lat_qb = 1'b1;
      tick(8);
      check_eq("hold_v_count", err_count, 1);
      check_eq("hold_v_last", last_err, 2'b10);
      check_eq("hold_v_flag", err_flag, 1);
      tick(8);
      check_eq("hold_v_once", err_count, 1);
      lat_q = 1'b1; lat_qb = 1'b0;
      tick(2);
      pulse_clr();

      // complement mismatch twice
      lat_qb = 1'b1;
      tick(10);
      lat_qb = 1'b0;
      tick(3);
      lat_qb = 1'b1;
      tick(5);
      lat_qb = 1'b0;
      tick(3);
      check_eq("comp_count", err_count, 2);
      check_eq("comp_last", last_err, 2'b11);
      check_eq("comp_state", state, 2'b10);

      // disable: IDLE, counters kept, no checks
      en = 1'b0;
      tick(3);
      check_eq("idle_state", state, 2'b00);
      set_lat(1, 1, 0, 0);
      tick(8);
      check_eq("idle_count_kept", err_count, 2);
      lat_qb = 1'b1;
      tick(3);
      pulse_clr();
      tick(2);

      // re-enable: first follow check lands MAX_DELAY+2 edges after en
      en = 1'b1;
      tick(5);
      check_eq("reen_early", err_count, 0);
      tick(1);
      check_eq("reen_count", err_count, 1);
      check_eq("reen_last", last_err, 2'b01);

      // d changes as gate falls -> hold check skipped
      lat_q = 1'b1; lat_qb = 1'b0;
      tick(10);
      pulse_clr();
      set_lat(0, 1, 0, 1);
      tick(10);
      check_eq("amb_pre_count", err_count, 0);
      lat_g = 1'b0; lat_d = 1'b1;
      tick(12);
      check_eq("amb_count", err_count, 0);
      check_eq("amb_state", state, 2'b10);

      // 20 complement onsets: full counter 20, narrow counter saturates
      for (int i = 0; i < 20; i++) begin
         lat_qb = 1'b0;
         tick(2);
         lat_qb = 1'b1;
         tick(2);
      end
      check_eq("sat_main_count", err_count, 20);
      check_eq("sat_main_last", last_err, 2'b11);
      check_eq("sat_narrow_count", err_count_s, 4'hf);
      check_eq("sat_narrow_flag", err_flag_s, 1);
      check_eq("sat_narrow_last", last_err_s, 2'b11);
      check_eq("sat_narrow_state", state_s, 2'b10);

      // violation and clr in the same cycle: clr wins
      lat_qb = 1'b0;
      tick(1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check_eq("clrwin_count", err_count, 0);
      check_eq("clrwin_flag", err_flag, 0);
      check_eq("clrwin_last", last_err, 2'b00);
      check_eq("clrwin_narrow", err_count_s, 0);
      tick(2);
      check_eq("clrwin_no_relog", err_count, 0);

      // reset with a violation pending
      lat_qb = 1'b1;
      tick(2);
      lat_qb = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_eq("rst_pend_count", err_count, 0);
      check_eq("rst_pend_state", state, 2'b00);
      check_eq("rst_pend_flag", err_flag, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
